// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths, FSM state encoding and register indices
//
// Contents:
//   APB_ADDR_W / APB_DATA_W : bus widths
//   apb_state_e             : completer FSM states (IDLE, ACCESS)
//   IDX_CTRL / IDX_STATUS   : fixed register indices
package apb_pkg;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam logic [5:0] IDX_CTRL   = 6'd0;
    localparam logic [5:0] IDX_STATUS = 6'd1;

endpackage

// File: rtl/apb_reg_decode.sv
// rtl/apb_reg_decode.sv - maps a latched APB request to register index, ro and err flags
//
// Ports:
//   addr  in   latched byte address
//   write in   latched direction (1 = write)
//   idx   out  word index addr[7:2]
//   ro    out  index is read-only (STATUS or ID)
//   err   out  access must complete with an error response
module apb_reg_decode
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic [APB_ADDR_W-1:0] addr,
    input  logic                  write,
    output logic [5:0]            idx,
    output logic                  ro,
    output logic                  err
);

    logic misaligned;
    logic out_of_page;
    logic out_of_range;

    assign idx          = addr[7:2];
    assign misaligned   = (addr[1:0] != 2'b00);
    assign out_of_page  = (addr[15:8] != 8'h00);
    // Compare in 7 bits so NUM_REGS=64 does not truncate to zero.
    assign out_of_range = ({1'b0, idx} >= 7'(NUM_REGS));
    assign ro           = (idx == IDX_STATUS) || (idx == 6'(NUM_REGS - 1));
    assign err          = misaligned || out_of_page || out_of_range || (write && ro);

endmodule

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB completer serving a small 32-bit register file
//
// Ports:
//   PCLK, PRESET        clock, asynchronous active-high reset
//   PSEL, PENABLE       APB select and access-phase strobe
//   PWRITE, PADDR       direction and byte address
//   PWDATA              write data
//   PRDATA              read data (non-zero only on a completing, error-free read)
//   PREADY, PSLVERR     completion handshake and error response
//   status_i            local status word, readable at index 1
//   ctrl_o              registered copy of CTRL (index 0)
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int              NUM_REGS    = 8,
    parameter int              WAIT_STATES = 1,
    parameter logic [31:0]     ID_VALUE    = 32'hA5B2_0001
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic [APB_DATA_W-1:0] PWDATA,
    output logic [APB_DATA_W-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [APB_DATA_W-1:0] status_i,
    output logic [APB_DATA_W-1:0] ctrl_o
);

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_ACCESS = ACCESS;

    logic [0:0]            state;
    logic [3:0]            wait_cnt;
    logic [APB_ADDR_W-1:0] lat_addr;
    logic                  lat_write;
    logic [APB_DATA_W-1:0] lat_wdata;
    logic [APB_DATA_W-1:0] regs [NUM_REGS];

    logic [5:0]            dec_idx;
    logic                  dec_ro;
    logic                  dec_err;

    logic                  setup_violation;
    logic                  access_done;
    logic [APB_DATA_W-1:0] rdata;

    apb_reg_decode #(
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .addr  (lat_addr),
        .write (lat_write),
        .idx   (dec_idx),
        .ro    (dec_ro),
        .err   (dec_err)
    );

    // An access phase seen from IDLE has no setup behind it: answer with an
    // immediate error and leave all state untouched.
    assign setup_violation = (state == ST_IDLE) && PSEL && PENABLE;
    assign access_done     = (state == ST_ACCESS) && (wait_cnt == 4'd0) && PSEL && PENABLE;

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dec_idx == 6'(i)) begin
                rdata = regs[i];
            end
        end
        if (dec_idx == IDX_STATUS) begin
            rdata = status_i;
        end else if (dec_idx == 6'(NUM_REGS - 1)) begin
            rdata = ID_VALUE;
        end
    end

    // Outputs are forced low while reset is held so an in-flight bus cycle
    // cannot look like a protocol violation during reset.
    assign PREADY  = !PRESET && (setup_violation || access_done);
    assign PSLVERR = !PRESET && (setup_violation || (access_done && dec_err));
    assign PRDATA  = (!PRESET && access_done && !lat_write && !dec_err) ? rdata : '0;
    assign ctrl_o  = regs[IDX_CTRL];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        lat_addr  <= PADDR;
                        lat_write <= PWRITE;
                        lat_wdata <= PWDATA;
                        wait_cnt  <= 4'(WAIT_STATES);
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL) begin
                        state <= ST_IDLE;
                    end else if (PENABLE) begin
                        if (wait_cnt != 4'd0) begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end else begin
                            // dec_err already rejects RO indices on writes.
                            if (lat_write && !dec_err) begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (dec_idx == 6'(i)) begin
                                        regs[i] <= lat_wdata;
                                    end
                                end
                            end
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - table-driven scoreboard bench for apb_reg_slave
module tb_apb_reg_slave;

    logic        PCLK;
    logic        PRESET;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] status;
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [31:0] prdata [3];
    logic [31:0] ctrl   [3];

    int total;
    int passed;

    typedef struct {
        int          dut;
        bit          write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_cycles;
        string       name;
    } vec_t;

    vec_t tbl [$];
    vec_t sb  [$];

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Three instances cover the three wait-state settings; they share the
    // bus and are told apart by their PSEL bit.
    apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(1), .ID_VALUE(32'hA5B2_0001)) u_ws1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0]), .status_i(status), .ctrl_o(ctrl[0])
    );
    apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(0), .ID_VALUE(32'hA5B2_0001)) u_ws0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1]), .status_i(status), .ctrl_o(ctrl[1])
    );
    apb_reg_slave #(.NUM_REGS(8), .WAIT_STATES(3), .ID_VALUE(32'hA5B2_0001)) u_ws3 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]),
        .PREADY(pready[2]), .PSLVERR(pslverr[2]), .status_i(status), .ctrl_o(ctrl[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Caller enters #1 after a rising edge; returns #1 after the edge that
    // ends the transfer, so a following call is back-to-back.
    task automatic xfer(input vec_t v);
        int          cyc;
        bit          done;
        logic [31:0] got_rd;
        logic        got_err;
        vec_t        e;
        sb.push_back(v);
        psel       = 3'b000;
        psel[v.dut] = 1'b1;
        penable    = 1'b0;
        pwrite     = v.write;
        paddr      = v.addr;
        pwdata     = v.wdata;
        @(posedge PCLK); #1;
        penable = 1'b1;
        paddr   = ~v.addr;
        pwdata  = ~v.wdata;
        cyc     = 2;
        done    = 1'b0;
        got_rd  = '0;
        got_err = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge PCLK);
            if (pready[v.dut]) begin
                got_rd  = prdata[v.dut];
                got_err = pslverr[v.dut];
                done    = 1'b1;
            end else begin
                @(posedge PCLK); #1;
                cyc++;
            end
        end
        e = sb.pop_front();
        if (!done) begin
            total++;
            $display("FAIL %s_timeout: got no PREADY, expected PREADY within 40 cycles", e.name);
        end else begin
            chk({e.name, "_rdata"}, got_rd, e.exp_rdata);
            chk({e.name, "_err"}, 32'(got_err), 32'(e.exp_err));
            chk({e.name, "_cycles"}, 32'(cyc), 32'(e.exp_cycles));
        end
        @(posedge PCLK); #1;
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK); #1;
        end
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        PRESET  = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        status  = 32'h0000_1234;

        tbl.push_back('{0, 1'b1, 16'h0000, 32'hDEAD_BEEF, 32'h0,         1'b0, 3, "ws1_wr_ctrl"});
        tbl.push_back('{0, 1'b0, 16'h0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, "ws1_rd_ctrl"});
        tbl.push_back('{0, 1'b0, 16'h0004, 32'h0,         32'h0000_1234, 1'b0, 3, "ws1_rd_status"});
        tbl.push_back('{0, 1'b1, 16'h0004, 32'hFFFF_FFFF, 32'h0,         1'b1, 3, "ws1_wr_status_ro"});
        tbl.push_back('{0, 1'b0, 16'h0004, 32'h0,         32'h0000_1234, 1'b0, 3, "ws1_rd_status2"});
        tbl.push_back('{0, 1'b0, 16'h001C, 32'h0,         32'hA5B2_0001, 1'b0, 3, "ws1_rd_id"});
        tbl.push_back('{0, 1'b0, 16'h0020, 32'h0,         32'h0,         1'b1, 3, "ws1_rd_oob"});
        tbl.push_back('{0, 1'b1, 16'h0002, 32'h1234_5678, 32'h0,         1'b1, 3, "ws1_wr_misalign"});
        tbl.push_back('{0, 1'b1, 16'h0100, 32'h1234_5678, 32'h0,         1'b1, 3, "ws1_wr_hipage"});
        tbl.push_back('{0, 1'b1, 16'h001C, 32'h1234_5678, 32'h0,         1'b1, 3, "ws1_wr_id_ro"});
        tbl.push_back('{0, 1'b0, 16'h0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, "ws1_rd_ctrl_kept"});
        tbl.push_back('{0, 1'b1, 16'h0010, 32'h0BAD_F00D, 32'h0,         1'b0, 3, "ws1_wr_scratch"});
        tbl.push_back('{0, 1'b0, 16'h0010, 32'h0,         32'h0BAD_F00D, 1'b0, 3, "ws1_rd_scratch"});
        tbl.push_back('{0, 1'b0, 16'h0006, 32'h0,         32'h0,         1'b1, 3, "ws1_rd_misalign"});
        tbl.push_back('{1, 1'b1, 16'h0008, 32'h1111_1111, 32'h0,         1'b0, 2, "ws0_wr_s2"});
        tbl.push_back('{1, 1'b1, 16'h000C, 32'h2222_2222, 32'h0,         1'b0, 2, "ws0_wr_s3"});
        tbl.push_back('{1, 1'b0, 16'h0008, 32'h0,         32'h1111_1111, 1'b0, 2, "ws0_rd_s2"});
        tbl.push_back('{1, 1'b0, 16'h000C, 32'h0,         32'h2222_2222, 1'b0, 2, "ws0_rd_s3"});
        tbl.push_back('{2, 1'b1, 16'h0008, 32'hCAFE_0001, 32'h0,         1'b0, 5, "ws3_wr_s2"});
        tbl.push_back('{2, 1'b0, 16'h0008, 32'h0,         32'hCAFE_0001, 1'b0, 5, "ws3_rd_s2"});

        // Reset state.
        @(negedge PCLK);
        chk("rst_pready", 32'(pready), 32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        chk("rst_prdata", prdata[0], 32'h0);
        chk("rst_ctrl", ctrl[0], 32'h0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        idle(1);

        // Table: transfers run back-to-back with no idle cycle in between.
        for (int i = 0; i < tbl.size(); i++) begin
            xfer(tbl[i]);
            if (i == 0) begin
                @(negedge PCLK);
                chk("ctrl_o_after_wr", ctrl[0], 32'hDEAD_BEEF);
                @(posedge PCLK); #1;
            end
        end
        chk("ctrl_o_ws1_final", ctrl[0], 32'hDEAD_BEEF);

        // Access phase with no setup from IDLE: immediate error, no write.
        idle(1);
        psel    = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 16'h0000;
        pwdata  = 32'h0000_0077;
        @(negedge PCLK);
        chk("viol_pready", 32'(pready[0]), 32'h1);
        chk("viol_pslverr", 32'(pslverr[0]), 32'h1);
        @(posedge PCLK); #1;
        psel    = 3'b000;
        penable = 1'b0;
        idle(1);
        xfer('{0, 1'b0, 16'h0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, "viol_rd_ctrl"});

        // Abort: PSEL drops after one access cycle of a WS=3 write.
        idle(1);
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 16'h0008;
        pwdata  = 32'hDEAD_DEAD;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        chk("abort_pready", 32'(pready[2]), 32'h0);
        @(posedge PCLK); #1;
        psel    = 3'b000;
        penable = 1'b0;
        @(negedge PCLK);
        chk("abort_pready_after", 32'(pready[2]), 32'h0);
        @(posedge PCLK); #1;
        idle(2);
        xfer('{2, 1'b0, 16'h0008, 32'h0, 32'hCAFE_0001, 1'b0, 5, "abort_rd_s2"});

        // Reset during the access phase of a write.
        xfer('{2, 1'b1, 16'h0000, 32'h0000_0055, 32'h0, 1'b0, 5, "ws3_wr_ctrl"});
        @(negedge PCLK);
        chk("ws3_ctrl_o", ctrl[2], 32'h0000_0055);
        @(posedge PCLK); #1;
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 16'h0008;
        pwdata  = 32'h0000_0099;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        #1;
        chk("midrst_pready", 32'(pready), 32'h0);
        chk("midrst_pslverr", 32'(pslverr), 32'h0);
        chk("midrst_prdata", prdata[2], 32'h0);
        chk("midrst_ctrl_ws3", ctrl[2], 32'h0);
        chk("midrst_ctrl_ws1", ctrl[0], 32'h0);
        @(posedge PCLK); #1;
        PRESET  = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        idle(1);
        xfer('{2, 1'b0, 16'h0008, 32'h0, 32'h0, 1'b0, 5, "postrst_rd_s2"});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
